shannon_whitaker_interp: RTL
============================

Name: shannon_whitaker_interp

Overview:
- 2x half-band interpolator; the complement of the 8-sample-per-clock half-band lowpass/decimation path.
- Takes 4 samples/clk at the low rate and produces 8 samples/clk at the high rate.
- Even outputs are delayed copies of the input. Odd outputs come from the same 8 symmetric half-band coefficients, scaled for gain 2.
- Sits between a low-rate processing stage and the high-rate DAC/trigger datapath.

Parameters:
- INBITS, 12, signed input sample width.
- OUTBITS, INBITS+1 (localparam), signed output sample width.
- NIN, 4 (localparam), input samples per clock.
- NOUT, 8 (localparam), output samples per clock.

Ports:
- clk_i  in  1  sole clock.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- dat_i  in  [NIN-1:0][INBITS-1:0]  input beat; index 0 is the earliest sample.
- dat_valid_i  in  1  input beat valid.
- dat_o  out  [NOUT-1:0][OUTBITS-1:0]  output beat; index 0 is the earliest sample.
- dat_valid_o  out  1  output beat valid.

Behaviour:
- Sample indexing: input beat j carries x[4j..4j+3].
- Coefficients (Q14, nearest tap first): C0..C7 = 10342, -3216, 1672, -949, 526, -263, 105, -23.
- Even output: y[2m] = x[m].
- Odd output: y[2m+1] = sat(round(sum over k=0..7 of Ck*(x[m-k] + x[m+1+k]) / 2^14)).
- Arithmetic:
  - Pre-add width INBITS+1.
  - Products and sum use full precision, at least 36 bits.
  - Round half-up: add 2^13, then arithmetic shift right by 14.
  - Clamp to [-2^(OUTBITS-1), 2^(OUTBITS-1)-1].
  - Even outputs are sign-extended.
  - DC gain is 16388/16384.
- Output mapping: the output beat for input beat j holds m = 4(j-2)..4(j-2)+3. dat_o[2i] = y[2m] and dat_o[2i+1] = y[2m+1], with m = 4(j-2)+i.
- History: beats j-4..j are required (x[4j-15]..x[4j+3]).
- Latency: fixed LAT = 5 clocks from a beat at dat_i to its output beat at dat_o. This is a localparam. Stages:
  1. input register
  2. pre-add
  3. multiply
  4. adder tree
  5. round/saturate register
- Valid handling:
  - The pipeline advances every clock; there is no stall.
  - A beat with dat_valid_i=0 enters the history as all zeros.
  - fill_cnt is a 3-bit saturating counter. It increments on each valid beat, saturates at 5, and clears to 0 on any invalid beat.
  - dat_valid_o equals (dat_valid_i AND fill_cnt_next>=5), delayed by LAT clocks.
  - So the first output after reset or a gap appears on the 5th consecutive valid beat, LAT clocks later.
- Output data while dat_valid_o=0 is don't-care, but must be deterministic (zeros after reset).
- Reset (async assert, sync release):
  - Clears all history, pipeline, fill_cnt and valid delay line.
  - dat_o = 0 and dat_valid_o = 0.
  - Reset mid-stream discards in-flight beats; no dat_valid_o pulse may appear from pre-reset data.
- Simultaneous gap and fill: an invalid beat at fill_cnt=4 leaves the count at 0, and no output becomes valid.
- Saturation is reachable at INBITS=12: worst-case magnitude is 34192*2047/2^14 ≈ 4272. It must clamp and must not wrap.

Decomposition:
- Package shannon_whitaker_pkg holds:
  - coefficient array C0..C7 (18-bit signed)
  - localparam SCALE_SHIFT = 14
  - LAT = 5
  - FILL_BEATS = 5
- One sub-module, sw_interp_phase, computes one odd output from 16 history taps (8 pre-adds, 8 multiplies, adder tree, round/sat).
- The top instantiates 4 copies of sw_interp_phase and owns:
  - history registers
  - even-path delay
  - fill counter
  - valid delay line

Test Plan:
- Reset, then continuous zero input with valid -> dat_valid_o rises exactly LAT clocks after the 5th valid beat; all dat_o = 0.
- Impulse: x[m0]=1000, all other samples 0 -> y[2m0]=1000; y[2m0±1]=631; y[2m0±3]=-196; y[2m0±5]=102; y[2m0±7]=-58; y[2m0±9]=32; y[2m0±11]=-16; y[2m0±13]=6; y[2m0±15]=-1; all other outputs 0.
- DC input 1000 on all samples -> every valid output sample = 1000 (odd: 1000.24 rounds to 1000).
- Worst-case pattern: x[m-k] = x[m+1+k] = 2047*sign(Ck) -> odd output = 4095 (saturated, not wrapped). Negated pattern with -2048 -> -4096.
- Drop dat_valid_i for 1 beat mid-stream -> dat_valid_o deasserts and stays low until 5 consecutive valid beats + LAT clocks; zeros are injected for the gap beat.
- Assert rst_ni low asynchronously mid-stream -> dat_o and dat_valid_o go to 0 immediately. After release, no valid output appears before 5 valid beats + LAT clocks.

Source files
------------

// File: rtl/shannon_whitaker_pkg.sv
// Shared constants for the 2x half-band interpolator: beat geometry, half-band
// coefficients, arithmetic widths and pipeline depth.
package shannon_whitaker_pkg;

    localparam int unsigned NIN         = 4;
    localparam int unsigned NOUT        = 8;
    localparam int unsigned NTAPS       = 8;
    localparam int unsigned NHIST       = 5 * NIN - 1;
    localparam int unsigned COEF_W      = 18;
    localparam int unsigned SUM_W       = 36;
    localparam int unsigned SCALE_SHIFT = 14;
    localparam int unsigned LAT         = 5;
    localparam int unsigned FILL_BEATS  = 5;
    localparam int unsigned FILL_W      = 3;

    // Q14 half-band taps, nearest first; scaled for an overall gain of 2
    localparam logic signed [COEF_W-1:0] COEF [NTAPS] = '{
        18'sd10342, -18'sd3216, 18'sd1672, -18'sd949,
        18'sd526,   -18'sd263,  18'sd105,  -18'sd23
    };

endpackage

// File: rtl/sw_interp_phase.sv
// One odd-phase output: symmetric pre-add, multiply, adder tree, round/saturate.
// taps[t] holds x[m-7+t]; result is y[2m+1], four register stages deep.
module sw_interp_phase
    import shannon_whitaker_pkg::*;
#(
    parameter int unsigned INBITS = 12,
    localparam int unsigned OUTBITS = INBITS + 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [2*NTAPS-1:0][INBITS-1:0]    taps,
    output logic [OUTBITS-1:0]                y
);

    localparam int unsigned PRE_W = INBITS + 1;
    localparam logic signed [SUM_W-1:0] RND_HALF = SUM_W'(2 ** (SCALE_SHIFT - 1));
    localparam logic signed [SUM_W-1:0] OUT_MAX  = SUM_W'((2 ** (OUTBITS - 1)) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MIN  = ~OUT_MAX;

    logic signed [PRE_W-1:0] pre_d  [NTAPS];
    logic signed [PRE_W-1:0] pre_q  [NTAPS];
    logic signed [SUM_W-1:0] prod_q [NTAPS];
    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] sum_q;
    logic signed [SUM_W-1:0] rnd;
    logic        [OUTBITS-1:0] sat_d;

    // Fold the symmetric pair x[m-k] + x[m+1+k] before the multiply
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            pre_d[k] = PRE_W'($signed(taps[NTAPS-1-k])) + PRE_W'($signed(taps[NTAPS+k]));
        end
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NTAPS; k++) begin
            sum_d = sum_d + prod_q[k];
        end
    end

    // Round half-up, then clamp instead of letting the narrow output wrap
    always_comb begin
        rnd = (sum_q + RND_HALF) >>> SCALE_SHIFT;
        if (rnd > OUT_MAX) begin
            sat_d = OUT_MAX[OUTBITS-1:0];
        end else if (rnd < OUT_MIN) begin
            sat_d = OUT_MIN[OUTBITS-1:0];
        end else begin
            sat_d = rnd[OUTBITS-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NTAPS; k++) begin
                pre_q[k]  <= '0;
                prod_q[k] <= '0;
            end
            sum_q <= '0;
            y     <= '0;
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                pre_q[k]  <= pre_d[k];
                prod_q[k] <= SUM_W'(pre_q[k]) * SUM_W'(COEF[k]);
            end
            sum_q <= sum_d;
            y     <= sat_d;
        end
    end

endmodule

// File: rtl/shannon_whitaker_interp.sv
// 2x half-band interpolator: 4 low-rate samples in, 8 high-rate samples out per clock.
// Even outputs are delayed inputs; odd outputs come from four sw_interp_phase lanes.
module shannon_whitaker_interp
    import shannon_whitaker_pkg::*;
#(
    parameter int unsigned INBITS = 12,
    localparam int unsigned OUTBITS = INBITS + 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NIN-1:0][INBITS-1:0]       dat_i,
    input  logic                             dat_valid_i,
    output logic [NOUT-1:0][OUTBITS-1:0]     dat_o,
    output logic                             dat_valid_o
);

    // hist[0] is x[4j-15], hist[NHIST-1] is x[4j+3] for the newest beat j
    logic [NHIST-1:0][INBITS-1:0]  hist;
    logic [NIN-1:0][INBITS-1:0]    beat_in;
    logic [NIN-1:0][INBITS-1:0]    ev_d1;
    logic [NIN-1:0][INBITS-1:0]    ev_d2;
    logic [NIN-1:0][INBITS-1:0]    ev_d3;
    logic [NIN-1:0][OUTBITS-1:0]   even_q;
    logic [NIN-1:0][OUTBITS-1:0]   odd;
    logic [FILL_W-1:0]             fill_cnt;
    logic [FILL_W-1:0]             fill_next;
    logic                          valid_in;
    logic [LAT-1:0]                vld_q;

    // Invalid beats enter the history as zeros; any gap restarts the fill count
    always_comb begin
        beat_in = dat_valid_i ? dat_i : '0;
        if (!dat_valid_i) begin
            fill_next = '0;
        end else if (fill_cnt >= FILL_W'(FILL_BEATS)) begin
            fill_next = FILL_W'(FILL_BEATS);
        end else begin
            fill_next = fill_cnt + FILL_W'(1);
        end
        valid_in = dat_valid_i && (fill_next >= FILL_W'(FILL_BEATS));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist     <= '0;
            ev_d1    <= '0;
            ev_d2    <= '0;
            ev_d3    <= '0;
            even_q   <= '0;
            fill_cnt <= '0;
            vld_q    <= '0;
        end else begin
            hist     <= {beat_in, hist[NHIST-1:NIN]};
            ev_d1    <= hist[2*NIN-1 +: NIN];
            ev_d2    <= ev_d1;
            ev_d3    <= ev_d2;
            for (int i = 0; i < NIN; i++) begin
                even_q[i] <= OUTBITS'($signed(ev_d3[i]));
            end
            fill_cnt <= fill_next;
            vld_q    <= {vld_q[LAT-2:0], valid_in};
        end
    end

    // Lane i produces y[2m+1] for m = 4(j-2)+i from x[m-7..m+8]
    for (genvar i = 0; i < NIN; i++) begin : g_phase
        sw_interp_phase #(
            .INBITS (INBITS)
        ) u_phase (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .taps   (hist[i + 2*NTAPS - 1 : i]),
            .y      (odd[i])
        );
    end

    always_comb begin
        dat_o = '0;
        for (int i = 0; i < NIN; i++) begin
            dat_o[2*i]   = even_q[i];
            dat_o[2*i+1] = odd[i];
        end
    end

    assign dat_valid_o = vld_q[LAT-1];

endmodule
